// File: rtl/expmul_row_sched.sv
// expmul_row_sched
// ----------------
// Scalar sequencer for the expmul datapath of the online-softmax loop. It
// takes one attention score per key of the current query row. It keeps the
// running row maximum and issues the triple (m, m_prev, s) to expmul, tagged
// with first/last key flags. At row end it reports the final row maximum.
//
// Handshake contract (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. Valid must not depend on ready. Once valid
// is raised, the payload holds until the transfer.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   num_keys_in     keys in the row, sampled on the accept of a row's first
//                   score (0 is treated as 1)
//   score_vld_in    upstream score valid
//   score_rdy_out   upstream score ready
//   s_in            score, signed Q4.4
//   issue_vld_out   triple valid to expmul
//   issue_rdy_in    expmul ready
//   m_out           new running max
//   m_prev_out      previous running max
//   s_out           registered score
//   first_out       issued key is the first of its row
//   last_out        issued key is the last of its row
//   row_done_out    one-cycle pulse after the last key's issue transfer
//   m_final_out     final row max, held until the next row_done_out
//   busy_out        a row is in progress
//   uflow_out       (only with EXPMUL_SCHED_UFLOW_EN) m_out - s_out > 8.0,
//                   so the V weight underflows and accumulation may be skipped
//
// Build option: define EXPMUL_SCHED_UFLOW_EN to add uflow_out.
module expmul_row_sched #(
    parameter int SCORE_W    = 9,
    parameter int NUM_KEYS_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_KEYS_W-1:0] num_keys_in,
    input  logic                  score_vld_in,
    output logic                  score_rdy_out,
    input  logic [SCORE_W-1:0]    s_in,
    output logic                  issue_vld_out,
    input  logic                  issue_rdy_in,
    output logic [SCORE_W-1:0]    m_out,
    output logic [SCORE_W-1:0]    m_prev_out,
    output logic [SCORE_W-1:0]    s_out,
    output logic                  first_out,
    output logic                  last_out,
    output logic                  row_done_out,
    output logic [SCORE_W-1:0]    m_final_out,
    output logic                  busy_out
`ifdef EXPMUL_SCHED_UFLOW_EN
    ,
    output logic                  uflow_out
`endif
);

    logic [SCORE_W-1:0]    m_run;
    logic [NUM_KEYS_W-1:0] key_cnt;
    logic [NUM_KEYS_W-1:0] keys_lat;
    logic                  row_open;

    logic                  accept;
    logic                  handshake;
    logic [NUM_KEYS_W-1:0] lat_first;
    logic [NUM_KEYS_W-1:0] lat_eff;
    logic [NUM_KEYS_W-1:0] cnt_next;
    logic [SCORE_W-1:0]    m_next;
    logic [SCORE_W-1:0]    m_prev_next;
    logic                  last_next;

    // Single output stage: a new score can enter whenever the stage is empty
    // or is being drained in the same cycle.
    assign score_rdy_out = !issue_vld_out || issue_rdy_in;
    assign accept        = score_vld_in && score_rdy_out;
    assign handshake     = issue_vld_out && issue_rdy_in;

    always_comb begin
        lat_first   = (num_keys_in == '0) ? NUM_KEYS_W'(1) : num_keys_in;
        lat_eff     = lat_first;
        cnt_next    = NUM_KEYS_W'(1);
        m_next      = s_in;
        m_prev_next = s_in;
        if (row_open) begin
            lat_eff     = keys_lat;
            cnt_next    = key_cnt + NUM_KEYS_W'(1);
            m_prev_next = m_run;
            m_next      = ($signed(s_in) > $signed(m_run)) ? s_in : m_run;
        end
        last_next = (cnt_next == lat_eff);
    end

`ifdef EXPMUL_SCHED_UFLOW_EN
    // One extra bit keeps the difference of two extreme scores from wrapping.
    localparam logic signed [SCORE_W:0] UFLOW_TH = (SCORE_W+1)'(128);
    logic signed [SCORE_W:0] diff;
    logic                    uflow_next;

    always_comb begin
        diff       = $signed({m_next[SCORE_W-1], m_next}) - $signed({s_in[SCORE_W-1], s_in});
        uflow_next = (diff > UFLOW_TH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uflow_out <= 1'b0;
        end else if (accept) begin
            uflow_out <= uflow_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            m_run         <= '0;
            key_cnt       <= '0;
            keys_lat      <= '0;
            row_open      <= 1'b0;
            issue_vld_out <= 1'b0;
            m_out         <= '0;
            m_prev_out    <= '0;
            s_out         <= '0;
            first_out     <= 1'b0;
            last_out      <= 1'b0;
            row_done_out  <= 1'b0;
            m_final_out   <= '0;
            busy_out      <= 1'b0;
        end else begin
            row_done_out <= handshake && last_out;
            if (handshake && last_out) begin
                m_final_out <= m_out;
                busy_out    <= 1'b0;
            end
            if (accept) begin
                if (!row_open) begin
                    keys_lat <= lat_first;
                end
                key_cnt       <= cnt_next;
                row_open      <= !last_next;
                m_run         <= m_next;
                m_out         <= m_next;
                m_prev_out    <= m_prev_next;
                s_out         <= s_in;
                first_out     <= !row_open;
                last_out      <= last_next;
                issue_vld_out <= 1'b1;
                // A new key keeps the block busy even if the previous row's
                // last key drains in this same cycle.
                busy_out      <= 1'b1;
            end else if (handshake) begin
                issue_vld_out <= 1'b0;
            end
        end
    end

endmodule
